// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and register-map constants for the UART blocks.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;

    localparam int STATUS_FULL  = 0;
    localparam int STATUS_EMPTY = 1;
    localparam int STATUS_BUSY  = 2;
    localparam int STATUS_OVF   = 3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with free-running wrap-bit pointers.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign dout  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_mmio
// Brief    : Memory-mapped 8N1 UART transmitter with TX FIFO and status reg.
// Revision : 1.0
// ============================================================================
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int              c_divisor   = CLOCK_FREQ / BAUD_RATE;
    localparam int              c_cw        = (c_divisor > 1) ? $clog2(c_divisor) : 1;
    localparam logic [c_cw-1:0] c_baud_last = c_cw'(c_divisor - 1);

    tx_state_t       r_state;
    tx_state_t       w_state_next;
    logic [c_cw-1:0] r_baud;
    logic [c_cw-1:0] w_baud_next;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_tx;
    logic            w_tx_next;
    logic            r_ovf;

    logic            w_pop;
    logic            w_push_req;
    logic            w_push_ok;
    logic            w_ovf_clr;
    logic            w_baud_end;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [7:0]      w_fifo_dout;
    logic            w_unused;

    assign w_unused   = &{1'b0, addr[1:0], wdata[31:8]};
    assign w_push_req = sel & we & (addr[3:2] == UART_TXDATA);
    assign w_ovf_clr  = sel & we & (addr[3:2] == UART_STATUS) & wdata[STATUS_OVF];
    assign w_push_ok  = w_push_req & (~w_fifo_full | w_pop);
    assign w_baud_end = (r_baud == c_baud_last);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_ok),
        .pop   (w_pop),
        .din   (wdata[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + c_cw'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_dout;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_dout;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = IDLE;
            end
        endcase

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    // A fresh overflow outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_push_req && !w_push_ok) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (addr[3:2] == UART_STATUS) begin
            rdata[STATUS_FULL]  = w_fifo_full;
            rdata[STATUS_EMPTY] = w_fifo_empty;
            rdata[STATUS_BUSY]  = (r_state != IDLE);
            rdata[STATUS_OVF]   = r_ovf;
        end
    end

    assign tx  = r_tx;
    assign irq = w_fifo_empty & (r_state == IDLE);

endmodule : uart_tx_mmio
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_mmio
// Brief    : Directed self-checking bench for uart_tx_mmio (DIVISOR = 10).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    uart_tx_mmio #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus write lasting one edge; afterwards the address parks on STATUS.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 4'h4;
        wdata = '0;
        #1;
    endtask

    // Line level for bit slot idx (0 start, 1..8 data LSB first, 9 stop).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    logic [7:0] burst [10];
    int         lows;

    initial begin
        burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h81, 8'h24, 8'h99};
        rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 4'h4; wdata = '0;

        // Reset state
        tick(); tick();
        check("reset_tx", {31'b0, tx}, 32'h1);
        check("reset_status", rdata, 32'h2);
        check("reset_irq", {31'b0, irq}, 32'h1);
        rst = 1'b1;
        tick();

        // Single frame 0x55
        wr(4'h0, 32'h55);
        check("f55_pre_fall", {31'b0, tx}, 32'h1);
        tick();
        for (int i = 0; i < 100; i++) begin
            check($sformatf("f55_c%0d", i), {31'b0, tx}, {31'b0, frame_bit(8'h55, i / 10)});
            if (i == 50) begin
                check("f55_status_busy", rdata, 32'h6);
                check("f55_irq_busy", {31'b0, irq}, 32'h0);
            end
            tick();
        end
        check("f55_idle_tx", {31'b0, tx}, 32'h1);
        check("f55_idle_irq", {31'b0, irq}, 32'h1);

        // Back-to-back frames 0xA5, 0x3C
        tick();
        wr(4'h0, 32'hA5);
        wr(4'h0, 32'h3C);
        for (int i = 0; i < 200; i++) begin
            check($sformatf("b2b_c%0d", i), {31'b0, tx},
                  {31'b0, frame_bit((i < 100) ? 8'hA5 : 8'h3C, (i % 100) / 10)});
            tick();
        end
        check("b2b_idle_tx", {31'b0, tx}, 32'h1);
        check("b2b_idle_irq", {31'b0, irq}, 32'h1);

        // Ten writes into an 8-deep FIFO: the tenth is dropped
        tick();
        for (int k = 0; k < 10; k++) wr(4'h0, {24'b0, burst[k]});
        check("ovf_status", rdata, 32'hD);
        check("ovf_irq", {31'b0, irq}, 32'h0);
        addr = 4'h8; #1;
        check("ovf_rd_0x8", rdata, 32'h0);
        addr = 4'h0; #1;
        check("ovf_rd_0x0", rdata, 32'h0);
        addr = 4'h4; #1;
        check("ovf_sticky", rdata, 32'hD);
        wr(4'h4, 32'h8);
        check("ovf_cleared", rdata, 32'h5);
        for (int i = 9; i < 900; i++) begin
            check($sformatf("burst_c%0d", i), {31'b0, tx},
                  {31'b0, frame_bit(burst[i / 100], (i % 100) / 10)});
            tick();
        end
        check("burst_idle_tx", {31'b0, tx}, 32'h1);
        check("burst_idle_irq", {31'b0, irq}, 32'h1);
        check("burst_idle_status", rdata, 32'h2);

        // Reset at cycle 35 of a frame with bytes still queued
        tick();
        wr(4'h0, 32'hFB);
        wr(4'h0, 32'h11);
        wr(4'h0, 32'h22);
        for (int i = 1; i < 35; i++) tick();
        check("mid_c35_bit2", {31'b0, tx}, 32'h0);
        rst = 1'b0;
        tick();
        check("mid_rst_tx", {31'b0, tx}, 32'h1);
        check("mid_rst_status", rdata, 32'h2);
        check("mid_rst_irq", {31'b0, irq}, 32'h1);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("mid_no_frames", lows, 32'h0);
        check("mid_after_status", rdata, 32'h2);

        // Unmapped offsets
        addr = 4'h8; #1;
        check("rd_0x8", rdata, 32'h0);
        addr = 4'hC; #1;
        check("rd_0xC", rdata, 32'h0);
        wr(4'h8, 32'hFF);
        wr(4'hC, 32'h8);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        check("unmapped_tx_idle", lows, 32'h0);
        check("unmapped_status", rdata, 32'h2);
        check("unmapped_irq", {31'b0, irq}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_mmio
`default_nettype wire

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the Tile's data bus. It is the first output peripheral downstream of the single-cycle core: the core stores bytes, the block buffers them in a small FIFO and serialises them 8N1 on a TX pin. It also exposes a status register for polling. It gives tile-level simulation and FPGA runs a console output alongside the LEDs.

Parameters:
CLOCK_FREQ, 100_000_000, clk frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; DIVISOR = CLOCK_FREQ/BAUD_RATE (integer division, must be >= 2)
FIFO_DEPTH, 8, TX FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
sel  input  1  peripheral selected by core address decode
we  input  1  write enable (valid only with sel)
addr  input  4  byte offset; only addr[3:2] decoded
wdata  input  32  store data
rdata  output  32  load data, combinational from addr (single-cycle core)
tx  output  1  serial line, idle high
irq  output  1  high while FIFO empty and transmitter idle

Behaviour:
- Register map (word offsets): 0x0 TXDATA W: push wdata[7:0]; read returns 0. 0x4 STATUS R: bit0 full, bit1 empty, bit2 busy (state != IDLE), bit3 overflow (sticky); W: writing 1 to bit3 clears overflow. 0x8 and 0xC read 0, writes ignored.
- rdata is a pure function of addr and current state; sel is not required for reads; no read side effects.
- Reset (rst=0 at edge): FIFO empty, state IDLE, tx=1, bit counter 0, baud counter 0, overflow 0. irq=1 after reset. Reset mid-frame aborts the frame: tx returns high on the next cycle and buffered bytes are discarded.
- Push: sel&we&addr[3:2]==0 on an edge. Accepted if FIFO not full, or if a pop occurs on the same edge. Otherwise the byte is dropped and overflow is set to 1.
- Simultaneous push and pop on an empty FIFO: impossible, because pop requires non-empty. The pushed byte is sent in the following frame.
- FSM states IDLE, START, DATA, STOP; baud counter counts 0..DIVISOR-1.
- IDLE: if FIFO non-empty at an edge, pop the head into shift register, enter START, baud counter 0. tx drives 0 from the cycle after the pop. IDLE with empty FIFO keeps tx=1.
- START: tx=0 for DIVISOR cycles, then enter DATA with bit index 0.
- DATA: tx = shift[0] (LSB first); shift right every DIVISOR cycles; after bit index 7 completes, enter STOP.
- STOP: tx=1 for DIVISOR cycles. At the end edge, if FIFO non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- Frame length is exactly 10*DIVISOR cycles. Latency from accepting edge (push into idle, empty FIFO) to tx falling: 2 cycles (push edge, pop edge, tx=0 after).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide. Full when MSBs differ and the rest are equal; wrap-around is free-running.
- The STATUS write-1-to-clear and a new overflow on the same edge resolve to set.

Decomposition:
- Package uart_pkg holds: tx_state_t enum (IDLE, START, DATA, STOP), register offset constants (UART_TXDATA=2'd0, UART_STATUS=2'd1), and STATUS bit index constants.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty) is reusable for a future RX block.
- The Tile instantiates uart_tx_mmio and inverts its own active-high reset at the boundary.

Test Plan:
- CLOCK_FREQ=1000, BAUD_RATE=100 (DIVISOR=10), reset low 2 cycles -> tx=1, rdata@0x4 = 0x00000002, irq=1.
- Write 0x55 to 0x0 -> tx low 2 cycles after the write edge; next 100 cycles tx = 0,1,0,1,0,1,0,1,0,1 in 10-cycle bits, then idle high, irq returns 1.
- Write 0xA5 then 0x3C on consecutive cycles -> two frames back-to-back, 200 cycles total, no high gap between stop of frame 1 and start of frame 2; data bits LSB-first 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Write 10 bytes in 10 cycles with DEPTH=8 -> first popped after write 1, so 9 accepted and byte 10 dropped. STATUS reads full=1, overflow=1. Writing 0x8 to 0x4 clears overflow to 0.
- Reset asserted at cycle 35 of a frame -> tx=1 next cycle, STATUS=0x2, no further frames even with bytes previously queued.
- Reads of 0x8/0xC and write to 0x8 -> rdata=0, no state change, tx unaffected.
